// File: rtl/vmc_tb_pkg.sv
// Shared definitions for the Wishbone traffic generator.
// Holds the Wishbone CTI/BTE codes, the LFSR polynomial, the FSM state
// encoding and a helper that picks the burst type for a given burst length.
package vmc_tb_pkg;

  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiIncr    = 3'b010;
  localparam logic [2:0] CtiEob     = 3'b111;

  localparam logic [1:0] BteLinear = 2'b00;
  localparam logic [1:0] BteWrap4  = 2'b01;
  localparam logic [1:0] BteWrap8  = 2'b10;
  localparam logic [1:0] BteWrap16 = 2'b11;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form.
  localparam logic [31:0] LfsrPoly = 32'h80200003;

  typedef enum logic [1:0] {StIdle, StBurst, StGap, StDone} tg_state_e;

  function automatic logic [1:0] bte_for(input int unsigned burst_len, input bit wrap);
    logic [1:0] b;
    b = BteLinear;
    if (wrap) begin
      case (burst_len)
        4:       b = BteWrap4;
        8:       b = BteWrap8;
        16:      b = BteWrap16;
        default: b = BteLinear;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/vmc_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and step enable.
// Ports: clk, rst (sync, active high, loads SEED), load (reload SEED),
//        step (advance one state), value (current LFSR state).
module vmc_lfsr32
  import vmc_tb_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [31:0] value
);

  logic [31:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = SEED;
    end else if (step) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? LfsrPoly : 32'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= SEED;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/vmc_wb_traffic_gen.sv
// Wishbone B3 burst traffic generator and checker.
// Writes an LFSR pattern over a region in bursts, reads it back and counts
// mismatching beats.
// Ports: wb_clk/wb_rst (sync active-high reset), start/mode (operation
//        request), adr/bte/cti/cyc/stb/we/sel/dat/dat_i/ack (Wishbone master),
//        busy/done/timeout/err_cnt/err_adr (status).
module vmc_wb_traffic_gen
  import vmc_tb_pkg::*;
#(
  parameter int unsigned           DAT_WIDTH   = 32,
  parameter int unsigned           ADR_WIDTH   = 32,
  parameter logic [ADR_WIDTH-1:0]  BASE_ADR    = '0,
  parameter int unsigned           NR_OF_WORDS = 1024,
  parameter int unsigned           BURST_LEN   = 4,
  parameter int unsigned           WRAP        = 0,
  parameter logic [31:0]           SEED        = 32'h1,
  parameter int unsigned           TIMEOUT     = 255
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  output logic [ADR_WIDTH-1:0]   adr,
  output logic [1:0]             bte,
  output logic [2:0]             cti,
  output logic                   cyc,
  output logic                   stb,
  output logic                   we,
  output logic [DAT_WIDTH/8-1:0] sel,
  output logic [DAT_WIDTH-1:0]   dat,
  input  logic [DAT_WIDTH-1:0]   dat_i,
  input  logic                   ack,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [15:0]            err_cnt,
  output logic [ADR_WIDTH-1:0]   err_adr
);

  localparam int unsigned BLW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned WCW  = $clog2(NR_OF_WORDS + 1);
  localparam int unsigned WTW  = $clog2(TIMEOUT + 1);
  localparam int unsigned Reps = DAT_WIDTH / 32;
  localparam logic [ADR_WIDTH-1:0] AdrStep = ADR_WIDTH'(DAT_WIDTH / 8);
  localparam logic [1:0] BteCfg = bte_for(BURST_LEN, WRAP != 0);

  tg_state_e state_q, state_d;

  logic                 phase_rd_q;     // 0: write phase, 1: read phase
  logic                 rd_after_wr_q;  // mode 00/11: read phase follows write
  logic [ADR_WIDTH-1:0] adr_q;
  logic [BLW-1:0]       beat_cnt_q;
  logic [WCW-1:0]       word_cnt_q;
  logic [WTW-1:0]       wait_cnt_q;
  logic [15:0]          err_cnt_q;
  logic [ADR_WIDTH-1:0] err_adr_q;
  logic                 timeout_q;
  logic                 done_q;

  logic [31:0]          lfsr_val;
  logic [DAT_WIDTH-1:0] pattern;

  logic accept, beat_ack, last_beat, last_word, wait_expired, phase_end, switch_to_rd;

  assign pattern      = {Reps{lfsr_val}};
  assign accept       = (state_q == StIdle) && start;
  assign beat_ack     = (state_q == StBurst) && ack;
  assign last_beat    = beat_cnt_q == BLW'(BURST_LEN - 1);
  assign last_word    = word_cnt_q == WCW'(NR_OF_WORDS - 1);
  // A late ack in the expiry cycle still completes the beat.
  assign wait_expired = (state_q == StBurst) && !ack && (wait_cnt_q == WTW'(TIMEOUT - 1));
  assign phase_end    = beat_ack && last_word;
  assign switch_to_rd = phase_end && !phase_rd_q && rd_after_wr_q;

  vmc_lfsr32 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk  (wb_clk),
    .rst  (wb_rst),
    .load (accept || switch_to_rd),
    .step (beat_ack),
    .value(lfsr_val)
  );

  // State register
  always_ff @(posedge wb_clk) begin
    if (wb_rst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StBurst;
      StBurst: begin
        if (ack) begin
          if (last_beat) begin
            if (!last_word || switch_to_rd) state_d = StGap;
            else                            state_d = StDone;
          end
        end else if (wait_expired) begin
          state_d = StDone;
        end
      end
      StGap:   state_d = StBurst;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    cyc  = 1'b0;
    stb  = 1'b0;
    we   = 1'b0;
    cti  = CtiClassic;
    bte  = BteLinear;
    busy = (state_q == StBurst) || (state_q == StGap);
    if (state_q == StBurst) begin
      cyc = 1'b1;
      stb = 1'b1;
      we  = !phase_rd_q;
      bte = BteCfg;
      if (BURST_LEN > 1) cti = last_beat ? CtiEob : CtiIncr;
    end
  end

  assign adr     = adr_q;
  assign sel     = '1;
  assign dat     = pattern;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign err_cnt = err_cnt_q;
  assign err_adr = err_adr_q;

  // Datapath and status
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      phase_rd_q    <= 1'b0;
      rd_after_wr_q <= 1'b0;
      adr_q         <= BASE_ADR;
      beat_cnt_q    <= '0;
      word_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      err_cnt_q     <= '0;
      err_adr_q     <= '0;
      timeout_q     <= 1'b0;
      done_q        <= 1'b0;
    end else if (accept) begin
      phase_rd_q    <= (mode == 2'b10);
      rd_after_wr_q <= (mode[1] == mode[0]);
      adr_q         <= BASE_ADR;
      beat_cnt_q    <= '0;
      word_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      err_cnt_q     <= '0;
      err_adr_q     <= '0;
      timeout_q     <= 1'b0;
      done_q        <= 1'b0;
    end else if (beat_ack) begin
      wait_cnt_q <= '0;
      beat_cnt_q <= last_beat ? '0 : beat_cnt_q + BLW'(1);
      if (switch_to_rd) begin
        adr_q      <= BASE_ADR;
        word_cnt_q <= '0;
        phase_rd_q <= 1'b1;
      end else begin
        adr_q      <= adr_q + AdrStep;
        word_cnt_q <= word_cnt_q + WCW'(1);
      end
      if (phase_rd_q && (dat_i != pattern)) begin
        // err_cnt never wraps back to zero, so zero marks "no mismatch yet".
        if (err_cnt_q == 16'h0)    err_adr_q <= adr_q;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
      if (phase_end && !switch_to_rd) done_q <= 1'b1;
    end else if (wait_expired) begin
      timeout_q <= 1'b1;
      done_q    <= 1'b1;
    end else if (state_q == StBurst) begin
      wait_cnt_q <= wait_cnt_q + WTW'(1);
    end
  end

endmodule

// File: tb/tb_vmc_wb_traffic_gen.sv
// Directed bench for vmc_wb_traffic_gen. Three instances cover the linear
// 4-beat, wrapping 8-beat and single-beat 64-bit configurations, each behind
// a zero-wait memory slave that logs every acked beat.
module tb_vmc_wb_traffic_gen;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [63:0] dat;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [2:0] start_v = 3'b000;
  logic ack_en0 = 1'b1;
  logic corrupt0 = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // DUT0: 32-bit, BURST_LEN=4, 16 words, TIMEOUT=10
  logic [31:0] adr0, dat0, dat_i0, err_adr0;
  logic [3:0]  sel0;
  logic [2:0]  cti0;
  logic [1:0]  bte0;
  logic cyc0, stb0, we0, ack0, busy0, done0, timeout0;
  logic [15:0] err_cnt0;
  // DUT1: 32-bit, BURST_LEN=8, WRAP=1, 16 words
  logic [31:0] adr1, dat1, dat_i1, err_adr1;
  logic [3:0]  sel1;
  logic [2:0]  cti1;
  logic [1:0]  bte1;
  logic cyc1, stb1, we1, ack1, busy1, done1, timeout1;
  logic [15:0] err_cnt1;
  // DUT2: 64-bit, BURST_LEN=1, 4 words
  logic [31:0] adr2, err_adr2;
  logic [63:0] dat2, dat_i2;
  logic [7:0]  sel2;
  logic [2:0]  cti2;
  logic [1:0]  bte2;
  logic cyc2, stb2, we2, ack2, busy2, done2, timeout2;
  logic [15:0] err_cnt2;

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  logic [63:0] mem2 [4];
  beat_t log0[$], log1[$], log2[$];
  int gap0, gap1, gap2, busycnt0;

  assign ack0   = cyc0 & stb0 & ack_en0;
  assign ack1   = cyc1 & stb1;
  assign ack2   = cyc2 & stb2;
  assign dat_i0 = mem0[adr0[5:2]] ^ ((corrupt0 && adr0 == 32'h24) ? 32'h1 : 32'h0);
  assign dat_i1 = mem1[adr1[5:2]];
  assign dat_i2 = mem2[adr2[4:3]];

  vmc_wb_traffic_gen #(
    .DAT_WIDTH(32), .ADR_WIDTH(32), .BASE_ADR(32'h0), .NR_OF_WORDS(16), .BURST_LEN(4),
    .WRAP(0), .SEED(32'h1), .TIMEOUT(10)
  ) dut0 (
    .wb_clk(clk), .wb_rst(rst), .start(start_v[0]), .mode(mode), .adr(adr0), .bte(bte0),
    .cti(cti0), .cyc(cyc0), .stb(stb0), .we(we0), .sel(sel0), .dat(dat0), .dat_i(dat_i0),
    .ack(ack0), .busy(busy0), .done(done0), .timeout(timeout0), .err_cnt(err_cnt0),
    .err_adr(err_adr0)
  );

  vmc_wb_traffic_gen #(
    .DAT_WIDTH(32), .ADR_WIDTH(32), .BASE_ADR(32'h0), .NR_OF_WORDS(16), .BURST_LEN(8),
    .WRAP(1), .SEED(32'h1), .TIMEOUT(255)
  ) dut1 (
    .wb_clk(clk), .wb_rst(rst), .start(start_v[1]), .mode(mode), .adr(adr1), .bte(bte1),
    .cti(cti1), .cyc(cyc1), .stb(stb1), .we(we1), .sel(sel1), .dat(dat1), .dat_i(dat_i1),
    .ack(ack1), .busy(busy1), .done(done1), .timeout(timeout1), .err_cnt(err_cnt1),
    .err_adr(err_adr1)
  );

  vmc_wb_traffic_gen #(
    .DAT_WIDTH(64), .ADR_WIDTH(32), .BASE_ADR(32'h0), .NR_OF_WORDS(4), .BURST_LEN(1),
    .WRAP(0), .SEED(32'h1), .TIMEOUT(255)
  ) dut2 (
    .wb_clk(clk), .wb_rst(rst), .start(start_v[2]), .mode(mode), .adr(adr2), .bte(bte2),
    .cti(cti2), .cyc(cyc2), .stb(stb2), .we(we2), .sel(sel2), .dat(dat2), .dat_i(dat_i2),
    .ack(ack2), .busy(busy2), .done(done2), .timeout(timeout2), .err_cnt(err_cnt2),
    .err_adr(err_adr2)
  );

  // Slave memories and beat/gap logging
  always @(posedge clk) begin
    if (cyc0 && stb0 && ack0) begin
      log0.push_back(beat_t'({adr0, we0, cti0, bte0, 64'(dat0)}));
      if (we0) mem0[adr0[5:2]] = dat0;
    end
    if (cyc1 && stb1 && ack1) begin
      log1.push_back(beat_t'({adr1, we1, cti1, bte1, 64'(dat1)}));
      if (we1) mem1[adr1[5:2]] = dat1;
    end
    if (cyc2 && stb2 && ack2) begin
      log2.push_back(beat_t'({adr2, we2, cti2, bte2, dat2}));
      if (we2) mem2[adr2[4:3]] = dat2;
    end
    if (busy0 && !cyc0) gap0++;
    if (busy1 && !cyc1) gap1++;
    if (busy2 && !cyc2) gap2++;
    if (busy0) busycnt0++;
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic clear_logs();
    log0.delete(); log1.delete(); log2.delete();
    gap0 = 0; gap1 = 0; gap2 = 0; busycnt0 = 0;
  endtask

  task automatic pulse_start(input int idx, input logic [1:0] m);
    @(negedge clk);
    mode = m;
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v = 3'b000;
  endtask

  task automatic wait_done(input int idx, input int budget, input string name);
    int n = 0;
    logic [2:0] dv;
    dv = {done2, done1, done0};
    while (dv[idx] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
      dv = {done2, done1, done0};
    end
    if (dv[idx] !== 1'b1) begin
      tests++; fails++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  // Compare a beat log against the expected write/read sequence.
  task automatic check_log(input int idx, input string name, input int n_wr, input int n_rd,
                           input int bl, input int step, input logic [1:0] bte_e, input bit wide);
    beat_t q[$];
    beat_t e;
    logic [31:0] s;
    int n, w;
    if (idx == 0) q = log0;
    else if (idx == 1) q = log1;
    else q = log2;
    tests++;
    if (q.size() !== n_wr + n_rd) begin
      fails++;
      $display("FAIL %s beats: got %0d expected %0d", name, q.size(), n_wr + n_rd);
    end
    n = (q.size() < n_wr + n_rd) ? q.size() : n_wr + n_rd;
    s = 32'h1;
    for (int i = 0; i < n; i++) begin
      w = (i < n_wr) ? i : i - n_wr;
      if (i == 0 || i == n_wr) s = 32'h1;
      else s = lfsr_step(s);
      e.adr = 32'(w * step);
      e.we  = (i < n_wr);
      e.cti = (bl == 1) ? 3'b000 : ((w % bl == bl - 1) ? 3'b111 : 3'b010);
      e.bte = bte_e;
      e.dat = wide ? {s, s} : {32'h0, s};
      tests++;
      if (q[i] !== e) begin
        fails++;
        $display("FAIL %s beat %0d: got adr=%h we=%b cti=%b bte=%b dat=%h expected adr=%h we=%b cti=%b bte=%b dat=%h",
                 name, i, q[i].adr, q[i].we, q[i].cti, q[i].bte, q[i].dat,
                 e.adr, e.we, e.cti, e.bte, e.dat);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset cyc/stb/we", {cyc0, stb0, we0}, 0);
    check_val("reset cti/bte", {cti0, bte0}, 0);
    check_val("reset adr", adr0, 0);
    check_val("reset dat", dat0, 32'h1);
    check_val("reset dat64", dat2, {32'h1, 32'h1});
    check_val("reset busy/done/timeout", {busy0, done0, timeout0}, 0);
    check_val("reset err_cnt", err_cnt0, 0);
    check_val("reset err_adr", err_adr0, 0);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    clear_logs();
    pulse_start(0, 2'b00);
    check_val("start latency cyc", {cyc0, stb0, busy0}, 3'b111);
    wait_done(0, 200, "write_read");
    check_log(0, "write_read", 16, 16, 4, 4, 2'b00, 1'b0);
    if (log0.size() >= 4) begin
      check_val("pattern beat0", log0[0].dat, 64'h1);
      check_val("pattern beat1", log0[1].dat, 64'h80200003);
      check_val("pattern beat2", log0[2].dat, 64'hC0300002);
      check_val("pattern beat3", log0[3].dat, 64'h60180001);
    end
    check_val("write_read err_cnt", err_cnt0, 0);
    check_val("write_read gaps", gap0, 7);
    check_val("write_read busy cycles", busycnt0, 39);
    repeat (3) @(negedge clk);
    check_val("done sticky in idle", {done0, busy0}, 2'b10);
  endtask

  task automatic test_fault();
    corrupt0 = 1'b1;
    clear_logs();
    pulse_start(0, 2'b11);
    wait_done(0, 200, "fault");
    corrupt0 = 1'b0;
    check_val("fault err_cnt", err_cnt0, 1);
    check_val("fault err_adr", err_adr0, 32'h24);
    check_val("fault beats (mode 11)", log0.size(), 32);
  endtask

  task automatic test_modes();
    clear_logs();
    pulse_start(0, 2'b01);
    wait_done(0, 200, "write_only");
    check_log(0, "write_only", 16, 0, 4, 4, 2'b00, 1'b0);
    check_val("write_only gaps", gap0, 3);
    clear_logs();
    pulse_start(0, 2'b10);
    wait_done(0, 200, "read_only");
    check_log(0, "read_only", 0, 16, 4, 4, 2'b00, 1'b0);
    check_val("read_only err_cnt", err_cnt0, 0);
  endtask

  task automatic test_wrap();
    clear_logs();
    pulse_start(1, 2'b00);
    wait_done(1, 200, "wrap");
    check_log(1, "wrap", 16, 16, 8, 4, 2'b10, 1'b0);
    check_val("wrap gaps", gap1, 3);
    check_val("wrap err_cnt", err_cnt1, 0);
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_logs();
    ack_en0 = 1'b0;
    pulse_start(0, 2'b01);
    for (int k = 0; k < 100 && (cyc0 || n == 0); k++) begin
      if (cyc0) n++;
      @(negedge clk);
    end
    check_val("timeout cyc cycles", n, 10);
    check_val("timeout flags", {timeout0, done0, busy0}, 3'b110);
    check_val("timeout no beats", log0.size(), 0);
    ack_en0 = 1'b1;
  endtask

  task automatic test_ack_at_expiry();
    int n = 0;
    clear_logs();
    ack_en0 = 1'b0;
    pulse_start(0, 2'b01);
    for (int k = 0; k < 100 && (cyc0 || n == 0); k++) begin
      if (cyc0) n++;
      ack_en0 = (n == 10);
      @(negedge clk);
    end
    ack_en0 = 1'b1;
    check_val("ack at expiry cyc cycles", n, 20);
    check_val("ack at expiry beats", log0.size(), 1);
    check_val("ack at expiry adr", adr0, 32'h4);
    check_val("ack at expiry timeout", timeout0, 1'b1);
  endtask

  task automatic test_reset_mid();
    // Status left by a faulty run must be wiped by reset.
    corrupt0 = 1'b1;
    pulse_start(0, 2'b00);
    wait_done(0, 200, "pre_reset");
    corrupt0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("idle reset status", {done0, err_cnt0, err_adr0}, 0);
    clear_logs();
    pulse_start(0, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid reset cyc/busy", {cyc0, stb0, busy0}, 0);
    check_val("mid reset adr", adr0, 0);
    check_val("mid reset dat", dat0, 32'h1);
    check_val("mid reset status", {done0, timeout0, err_cnt0}, 0);
    clear_logs();
    pulse_start(0, 2'b01);
    wait_done(0, 200, "restart");
    check_log(0, "restart", 16, 0, 4, 4, 2'b00, 1'b0);
  endtask

  task automatic test_single_beat();
    clear_logs();
    pulse_start(2, 2'b00);
    wait_done(2, 100, "single");
    check_log(2, "single", 4, 4, 1, 8, 2'b00, 1'b1);
    check_val("single gaps", gap2, 7);
    check_val("single err_cnt", err_cnt2, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    for (int i = 0; i < 4; i++) mem2[i] = 64'h0;
    gap0 = 0; gap1 = 0; gap2 = 0; busycnt0 = 0;
    test_reset();
    test_write_read();
    test_fault();
    test_modes();
    test_wrap();
    test_timeout();
    test_ack_at_expiry();
    test_reset_mid();
    test_single_beat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
